// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the score overlay renderer.
package score_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;

  typedef logic [3:0] bcd_t;

  // Digit code the glyph ROM renders as an all-blank cell.
  localparam bcd_t GLYPH_BLANK = 4'hF;

  function automatic logic bcd_is_nine(input bcd_t d);
    return (d == 4'd9);
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter with synchronous clear.
module bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  max
);

  logic [4*DIGITS-1:0] next_s;
  logic                next_max_s;
  logic                carry_s;
  bcd_t                digit_s;

  // Ripple-carry BCD increment; max is precomputed so it moves with value.
  always_comb begin
    next_s     = value;
    carry_s    = inc & ~max;
    digit_s    = 4'd0;
    next_max_s = 1'b1;
    if (clr) begin
      next_s = '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_s = value[4*i +: 4];
        if (carry_s) begin
          if (bcd_is_nine(digit_s)) begin
            next_s[4*i +: 4] = 4'd0;
          end else begin
            next_s[4*i +: 4] = digit_s + 4'd1;
            carry_s          = 1'b0;
          end
        end else begin
          next_s[4*i +: 4] = digit_s;
        end
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      next_max_s = next_max_s & bcd_is_nine(next_s[4*i +: 4]);
    end
  end

  // Counter state and saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      max   <= 1'b0;
    end else begin
      value <= next_s;
      max   <= next_max_s;
    end
  end

endmodule

// File: rtl/score_renderer.sv
// Score overlay: BCD score, per-frame display latch and a two-stage
// pixel pipeline that addresses an external glyph ROM.
module score_renderer
  import score_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int X0     = 16,
  parameter int Y0     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  score_inc,
  input  logic                  score_clr,
  input  logic                  frame_start,
  input  logic                  px_valid,
  input  logic [9:0]            px_x,
  input  logic [9:0]            px_y,
  output logic [3:0]            glyph_digit,
  output logic [3:0]            glyph_line,
  input  logic [15:0]           glyph_data,
  output logic                  pixel_on,
  output logic                  pixel_valid,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  score_max
);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + GLYPH_W * DIGITS);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + GLYPH_H);

  logic [4*DIGITS-1:0] disp_r;
  logic [9:0]          dx_s;
  logic [3:0]          dy_s;
  logic [5:0]          k_s;
  logic                in_box_s;
  bcd_t                sel_s;
  bcd_t                digit_s;
  logic [3:0]          line_s;
  logic [3:0]          col_s;
  logic [3:0]          col_r;
  logic                in_box_r;
  logic                valid_r;

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (score_inc),
    .clr   (score_clr),
    .value (score_bcd),
    .max   (score_max)
  );

  // Box hit test and glyph address; column k counts from the leftmost digit.
  always_comb begin
    dx_s     = px_x - X_LO;
    dy_s     = px_y[3:0] - Y_LO[3:0];
    k_s      = dx_s[9:4];
    in_box_s = px_valid && (px_x >= X_LO) && (px_x < X_HI) &&
               (px_y >= Y_LO) && (px_y < Y_HI);
    sel_s    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_s = sel_s | ((k_s == 6'(DIGITS - 1 - i)) ? disp_r[4*i +: 4] : 4'd0);
    end
    if (in_box_s) begin
      digit_s = sel_s;
      line_s  = dy_s;
      col_s   = dx_s[3:0];
    end else begin
      digit_s = GLYPH_BLANK;
      line_s  = 4'd0;
      col_s   = 4'd0;
    end
  end

  // Display copy and stage-1 registers; the copy sees the pre-update score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_r      <= '0;
      glyph_digit <= 4'd0;
      glyph_line  <= 4'd0;
      col_r       <= 4'd0;
      in_box_r    <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      if (frame_start) begin
        disp_r <= score_bcd;
      end
      glyph_digit <= digit_s;
      glyph_line  <= line_s;
      col_r       <= col_s;
      in_box_r    <= in_box_s;
      valid_r     <= px_valid;
    end
  end

  // Stage 2: pick the glyph bit; bit 15 of the ROM row is the leftmost pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= in_box_r & glyph_data[4'd15 - col_r];
      pixel_valid <= valid_r;
    end
  end

endmodule
